// File: rtl/instruction_loader.sv
// instruction_loader: assembles an MSB-first byte stream from the UART
// receiver into 32-bit instruction words and drives the fetch stage's
// instruction-memory write port. A session opens on START_CMD and ends on
// HALT_WORD, on the last memory address, on an inter-byte timeout or on i_clear.
module instruction_loader #(
  parameter int                SIZE            = 32,
  parameter int                MAX_INSTRUCTION = 64,
  parameter logic [7:0]        START_CMD       = 8'h55,
  parameter logic [SIZE-1:0]   HALT_WORD       = 32'hFFFFFFFF,
  parameter int                TIMEOUT_CYCLES  = 100000,
  localparam int               ADDR_WIDTH      = $clog2(MAX_INSTRUCTION)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_clear,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_loading,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SHIFT_W = SIZE - 8;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_INSTRUCTION - 1);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [1:0]         byte_cnt_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [TO_W-1:0]    timeout_q;
  logic [SIZE-1:0]    word_next;

  // The word that would be complete if the current strobe is its 4th byte.
  assign word_next = {shift_q, i_rx_data};

  // Session FSM, byte assembly, timeout and all registered outputs.
  // NOTE: every state register here uses non-blocking assignment so all
  // flops update together from pre-edge values; later assignments in the
  // same block intentionally override earlier defaults.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q             <= S_IDLE;
      byte_cnt_q          <= 2'd0;
      shift_q             <= '0;
      timeout_q           <= '0;
      o_inst_write_enable <= 1'b0;
      o_write_addr        <= '0;
      o_write_data        <= '0;
      o_loading           <= 1'b0;
      o_done              <= 1'b0;
      o_error             <= 1'b0;
      o_word_count        <= '0;
    end else begin
      o_inst_write_enable <= 1'b0;
      o_error             <= 1'b0;

      // Bookkeeping for the pulse issued last cycle; the address saturates
      // at the last slot because the full-memory word always ends the session.
      if (o_inst_write_enable) begin
        o_word_count <= o_word_count + CNT_W'(1);
        if (o_write_addr != LAST_ADDR) begin
          o_write_addr <= o_write_addr + ADDR_WIDTH'(1);
        end
      end

      if (i_clear) begin
        state_q    <= S_IDLE;
        o_loading  <= 1'b0;
        o_done     <= 1'b0;
        byte_cnt_q <= 2'd0;
        timeout_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_rx_valid && i_rx_data == START_CMD) begin
              state_q      <= S_RECV;
              o_loading    <= 1'b1;
              o_done       <= 1'b0;
              o_write_addr <= '0;
              o_word_count <= '0;
              byte_cnt_q   <= 2'd0;
              timeout_q    <= '0;
            end
          end

          S_RECV: begin
            if (i_rx_valid) begin
              timeout_q <= '0;
              if (byte_cnt_q == 2'd3) begin
                o_write_data        <= word_next;
                o_inst_write_enable <= 1'b1;
                byte_cnt_q          <= 2'd0;
                if (word_next == HALT_WORD || o_write_addr == LAST_ADDR) begin
                  state_q   <= S_DONE;
                  o_loading <= 1'b0;
                  o_done    <= 1'b1;
                end
              end else begin
                shift_q    <= {shift_q[SHIFT_W-9:0], i_rx_data};
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end
            end else if (timeout_q == TO_LAST) begin
              // Stalled transfer: drop the partial word, keep what was written.
              state_q    <= S_IDLE;
              o_loading  <= 1'b0;
              o_error    <= 1'b1;
              byte_cnt_q <= 2'd0;
              timeout_q  <= '0;
            end else begin
              timeout_q <= timeout_q + TO_W'(1);
            end
          end

          S_DONE: begin
            // Everything, including START_CMD, is ignored until i_clear.
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: a per-cycle vector table for
// single-word load, halt, DONE behaviour and the clear race, followed by
// hand-written sequences for reset, full-memory fill and timeout.
module tb_instruction_loader;

  localparam int TO = 20;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_clear;
  logic        o_inst_write_enable;
  logic [5:0]  o_write_addr;
  logic [31:0] o_write_data;
  logic        o_loading;
  logic        o_done;
  logic        o_error;
  logic [6:0]  o_word_count;

  always #5 i_clk = ~i_clk;

  instruction_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_rx_data           (i_rx_data),
    .i_rx_valid          (i_rx_valid),
    .i_clear             (i_clear),
    .o_inst_write_enable (o_inst_write_enable),
    .o_write_addr        (o_write_addr),
    .o_write_data        (o_write_data),
    .o_loading           (o_loading),
    .o_done              (o_done),
    .o_error             (o_error),
    .o_word_count        (o_word_count)
  );

  // Log every write pulse on the fetch stage's write edge.
  logic [37:0] wr_q[$];
  always @(negedge i_clk) begin
    if (!i_rst && o_inst_write_enable) wr_q.push_back({o_write_addr, o_write_data});
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        clr;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        ld;
    logic        dn;
    logic [6:0]  cnt;
  } vec_t;

  vec_t vecs[24];

  initial begin
    int n;
    int k;
    logic [31:0] w;

    // inputs (v d clr) / expected after the edge (we addr data ld dn cnt)
    vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 6'd0, 32'h00000000, 1'b1, 1'b0, 7'd0};
    vecs[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 6'd0, 32'h00000000, 1'b1, 1'b0, 7'd0};
    vecs[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 6'd0, 32'h00000000, 1'b1, 1'b0, 7'd0};
    vecs[3]  = '{1'b1, 8'h56, 1'b0, 1'b0, 6'd0, 32'h00000000, 1'b1, 1'b0, 7'd0};
    vecs[4]  = '{1'b1, 8'h78, 1'b0, 1'b1, 6'd0, 32'h12345678, 1'b1, 1'b0, 7'd0};
    vecs[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 6'd1, 32'h12345678, 1'b1, 1'b0, 7'd1};
    vecs[6]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 6'd1, 32'h12345678, 1'b1, 1'b0, 7'd1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 6'd1, 32'h12345678, 1'b1, 1'b0, 7'd1};
    vecs[8]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 6'd1, 32'h12345678, 1'b1, 1'b0, 7'd1};
    vecs[9]  = '{1'b1, 8'hDD, 1'b0, 1'b1, 6'd1, 32'hAABBCCDD, 1'b1, 1'b0, 7'd1};
    vecs[10] = '{1'b1, 8'hFF, 1'b0, 1'b0, 6'd2, 32'hAABBCCDD, 1'b1, 1'b0, 7'd2};
    vecs[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 6'd2, 32'hAABBCCDD, 1'b1, 1'b0, 7'd2};
    vecs[12] = '{1'b1, 8'hFF, 1'b0, 1'b0, 6'd2, 32'hAABBCCDD, 1'b1, 1'b0, 7'd2};
    vecs[13] = '{1'b1, 8'hFF, 1'b0, 1'b1, 6'd2, 32'hFFFFFFFF, 1'b0, 1'b1, 7'd2};
    vecs[14] = '{1'b1, 8'h55, 1'b0, 1'b0, 6'd3, 32'hFFFFFFFF, 1'b0, 1'b1, 7'd3};
    vecs[15] = '{1'b1, 8'h12, 1'b0, 1'b0, 6'd3, 32'hFFFFFFFF, 1'b0, 1'b1, 7'd3};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 6'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 7'd3};
    vecs[17] = '{1'b1, 8'h55, 1'b0, 1'b0, 6'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 7'd0};
    vecs[18] = '{1'b1, 8'h01, 1'b0, 1'b0, 6'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 7'd0};
    vecs[19] = '{1'b1, 8'h02, 1'b0, 1'b0, 6'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 7'd0};
    vecs[20] = '{1'b1, 8'h03, 1'b0, 1'b0, 6'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 7'd0};
    vecs[21] = '{1'b1, 8'h04, 1'b1, 1'b0, 6'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 7'd0};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 7'd0};
    vecs[23] = '{1'b1, 8'h04, 1'b0, 1'b0, 6'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 7'd0};

    i_rst      = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_clear    = 1'b0;

    // Reset state.
    #12;
    check("rst_we",   32'(o_inst_write_enable), 32'd0);
    check("rst_addr", 32'(o_write_addr),        32'd0);
    check("rst_data", o_write_data,             32'd0);
    check("rst_ld",   32'(o_loading),           32'd0);
    check("rst_done", 32'(o_done),              32'd0);
    check("rst_err",  32'(o_error),             32'd0);
    check("rst_cnt",  32'(o_word_count),        32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Table: single word, back-to-back byte during pulse, halt, DONE, clear race.
    for (int i = 0; i < 24; i++) begin
      i_rx_valid = vecs[i].v;
      i_rx_data  = vecs[i].d;
      i_clear    = vecs[i].clr;
      tick();
      i_rx_valid = 1'b0;
      i_clear    = 1'b0;
      check($sformatf("v%0d_we", i),   32'(o_inst_write_enable), 32'(vecs[i].we));
      check($sformatf("v%0d_addr", i), 32'(o_write_addr),        32'(vecs[i].addr));
      check($sformatf("v%0d_data", i), o_write_data,             vecs[i].data);
      check($sformatf("v%0d_ld", i),   32'(o_loading),           32'(vecs[i].ld));
      check($sformatf("v%0d_done", i), 32'(o_done),              32'(vecs[i].dn));
      check($sformatf("v%0d_cnt", i),  32'(o_word_count),        32'(vecs[i].cnt));
    end

    // Asynchronous reset mid-word with two bytes buffered.
    send(8'h55);
    send_word(32'hCAFE0001);
    send(8'h01);
    send(8'h02);
    check("pre_rst_ld",   32'(o_loading),    32'd1);
    check("pre_rst_addr", 32'(o_write_addr), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_we",   32'(o_inst_write_enable), 32'd0);
    check("arst_addr", 32'(o_write_addr),        32'd0);
    check("arst_data", o_write_data,             32'd0);
    check("arst_ld",   32'(o_loading),           32'd0);
    check("arst_cnt",  32'(o_word_count),        32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    n = wr_q.size();
    send_word(32'h11223344);
    tick();
    check("nostart_writes", 32'(wr_q.size()), 32'(n));
    check("nostart_ld",     32'(o_loading),   32'd0);

    // Fill all 64 slots back-to-back at one byte per cycle.
    send(8'h55);
    wr_q.delete();
    for (int i = 0; i < 64; i++) begin
      w = 32'h0100_0000 + 32'(i);
      send_word(w);
    end
    tick();
    check("fill_writes", 32'(wr_q.size()), 32'd64);
    for (int i = 0; i < 64 && i < wr_q.size(); i++) begin
      check($sformatf("fill%0d_addr", i), 32'(wr_q[i][37:32]), 32'(i));
      check($sformatf("fill%0d_data", i), wr_q[i][31:0],       32'h0100_0000 + 32'(i));
    end
    check("fill_done", 32'(o_done),       32'd1);
    check("fill_ld",   32'(o_loading),    32'd0);
    check("fill_cnt",  32'(o_word_count), 32'd64);
    check("fill_addr", 32'(o_write_addr), 32'd63);
    send_word(32'h55667788);
    tick();
    check("fill_after_writes", 32'(wr_q.size()), 32'd64);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check("fill_clear_done", 32'(o_done), 32'd0);

    // Timeout: start, two bytes, then silence.
    send(8'h55);
    send(8'hAA);
    n = wr_q.size();
    send(8'hBB);
    k = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (o_error) begin
        k = c;
        break;
      end
    end
    check("to_latency", 32'(k), 32'(TO));
    check("to_ld",      32'(o_loading), 32'd0);
    tick();
    check("to_err_pulse", 32'(o_error),     32'd0);
    check("to_writes",    32'(wr_q.size()), 32'(n));
    send(8'h55);
    send_word(32'h11223344);
    check("to_restart_we",   32'(o_inst_write_enable), 32'd1);
    check("to_restart_addr", 32'(o_write_addr),        32'd0);
    check("to_restart_data", o_write_data,             32'h11223344);
    tick();
    check("to_restart_cnt", 32'(o_word_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
